// File: rtl/shift_seq_if.sv
// Request/result bundle between the control FSM and the shift sequencer.
interface shift_seq_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;
  localparam int unsigned MODE_W = 2;

  logic              start;
  logic [MODE_W-1:0] op;
  logic [AMT_W-1:0]  amount;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] dout;

  modport master (output start, output op, output amount, output din,
                  input busy, input done, input dout);
  modport slave  (input start, input op, input amount, input din,
                  output busy, output done, output dout);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: one single-bit step per clock until the amount is spent.
// Build option SHIFT_SEQ_DOUBLE_STEP_EN applies two steps per cycle while >= 2 remain.
module shift_sequencer (
  input logic        clk,
  input logic        reset,
  shift_seq_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [AMT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // One single-bit step of the selected mode.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] w,
                                             input logic [MODE_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = w;
    case (m)
      2'b01:   r = {w[DATA_W-2:0], 1'b0};
      2'b10:   r = {1'b0, w[DATA_W-1:1]};
      2'b11:   r = {w[DATA_W-1], w[DATA_W-1:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; busy/done are registered copies of the next state.
  always_comb begin
    logic [DATA_W-1:0] nxt;
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    nxt     = work_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          work_d = bus.din;
          mode_d = bus.op;
          cnt_d  = bus.amount;
          if (bus.amount == AMT_W'(0)) begin
            state_d = S_DONE;
            dout_d  = bus.din;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        if (cnt_q >= AMT_W'(2)) begin
          nxt   = step(step(work_q, mode_q), mode_q);
          cnt_d = AMT_W'(cnt_q - AMT_W'(2));
        end else begin
          nxt   = step(work_q, mode_q);
          cnt_d = AMT_W'(cnt_q - AMT_W'(1));
        end
`else
        nxt   = step(work_q, mode_q);
        cnt_d = AMT_W'(cnt_q - AMT_W'(1));
`endif
        work_d = nxt;
        if (cnt_d == AMT_W'(0)) begin
          state_d = S_DONE;
          dout_d  = nxt;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer plus hand-written multi-cycle sequences.
module tb_shift_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_seq_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] a);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    return (int'(a) + 1) / 2;
`else
    return int'(a);
`endif
  endfunction

  // Issue one request and wait (bounded) for its done pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] amt,
                        input logic [15:0] din, input logic [15:0] exp);
    int cyc;
    int n;
    n = lat(amt);
    bus.op     = op;
    bus.amount = amt;
    bus.din    = din;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'(n != 0));
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(n));
    check({tag, "_dout"}, 32'(bus.dout), 32'(exp));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_single"}, 32'(bus.done), 32'd0);
    check({tag, "_dout_hold"}, 32'(bus.dout), 32'(exp));
  endtask

  initial begin
    int cyc;
    int n_done;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{op: 2'b01, amt: 4'd4,  din: 16'h0001, exp: 16'h0010};
    vecs[1] = '{op: 2'b11, amt: 4'd3,  din: 16'h8000, exp: 16'hF000};
    vecs[2] = '{op: 2'b10, amt: 4'd3,  din: 16'h8000, exp: 16'h1000};
    vecs[3] = '{op: 2'b00, amt: 4'd0,  din: 16'hBEEF, exp: 16'hBEEF};
    vecs[4] = '{op: 2'b00, amt: 4'd15, din: 16'hBEEF, exp: 16'hBEEF};
    vecs[5] = '{op: 2'b01, amt: 4'd15, din: 16'h0001, exp: 16'h8000};
    vecs[6] = '{op: 2'b11, amt: 4'd15, din: 16'h8000, exp: 16'hFFFF};
    vecs[7] = '{op: 2'b10, amt: 4'd1,  din: 16'hFFFF, exp: 16'h7FFF};
    vecs[8] = '{op: 2'b11, amt: 4'd5,  din: 16'h4000, exp: 16'h0200};
    vecs[9] = '{op: 2'b01, amt: 4'd7,  din: 16'h00FF, exp: 16'h7F80};

    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.amount = 4'd0;
    bus.din    = 16'h0000;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_dout", 32'(bus.dout), 32'h0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp);

    // Start pulsed mid-SHIFT with different operands must be dropped.
    bus.op = 2'b01; bus.amount = 4'd6; bus.din = 16'h0005; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.din = 16'hFFFF; bus.op = 2'b10; bus.amount = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_latency", 32'(cyc), 32'(lat(4'd6)));
    check("ign_dout", 32'(bus.dout), 32'h0140);
    @(posedge clk); #1;
    check("ign_no_restart", 32'(bus.busy), 32'd0);

    // Back-to-back: new start held through the done cycle.
    bus.op = 2'b01; bus.amount = 4'd2; bus.din = 16'h0001; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_first_dout", 32'(bus.dout), 32'h0004);
    bus.op = 2'b01; bus.amount = 4'd1; bus.din = 16'h0003; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_gap_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("b2b_second_done", 32'(bus.done), 32'd1);
    check("b2b_second_dout", 32'(bus.dout), 32'h0006);
    @(posedge clk); #1;

    // Reset mid-SHIFT aborts, with reset winning over a simultaneous start.
    bus.op = 2'b01; bus.amount = 4'd10; bus.din = 16'h0001; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1; bus.start = 1'b1; bus.amount = 4'd5;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'h0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_dout_stays", 32'(bus.dout), 32'h0);
    run_op("post_rst", 2'b01, 4'd2, 16'h0003, 16'h000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit datapath. It accepts one shift request: operand, shift mode and a 4-bit amount. It then applies a single-bit shift step once per clock until the amount is exhausted, and returns the result with a one-cycle `done` pulse. The block sits between the control FSM and the datapath, so shift instructions can encode shift distances of 0–15 while the shift hardware itself only ever moves by one bit per step.

## Interface

Parameters:
- none (datapath width fixed at 16, amount width fixed at 4)

Ports:
- `clk` — input, 1 — rising-edge clock; single clock domain.
- `reset` — input, 1 — synchronous, active-high reset.
- `start` — input, 1 — request strobe; sampled only while `busy` is 0.
- `op` — input, 2 — step mode:
  - 00: pass
  - 01: left by 1, zero fill
  - 10: logical right by 1
  - 11: arithmetic right by 1
- `amount` — input, 4 — number of steps, 0–15.
- `din` — input, 16 — operand.
- `busy` — output, 1 — high while in SHIFT.
- `done` — output, 1 — one-cycle pulse; result valid on `dout`.
- `dout` — output, 16 — result register.

## Operation

- States: IDLE, SHIFT, DONE. Encoding is free; `busy = (state == SHIFT)`.
- Internal registers:
  - `work[15:0]`: working value.
  - `mode[1:0]`: latched `op`.
  - `cnt[3:0]`: remaining steps.
- Start acceptance:
  - A start is accepted when `start` = 1 and state is IDLE or DONE.
  - On acceptance: `work <= din`, `mode <= op`, `cnt <= amount`.
  - If `amount` = 0, next state is DONE and `dout <= din`.
  - Otherwise next state is SHIFT.
- SHIFT, each cycle:
  - `work <= step(work, mode)` and `cnt <= cnt - 1`.
  - When `cnt` = 1: next state is DONE and `dout <= step(work, mode)`.
- DONE:
  - `done` = 1 for exactly this cycle.
  - Next state is IDLE, unless a new start is accepted (back-to-back requests).
- Inputs are ignored during SHIFT:
  - `start` while `busy` is dropped, not queued.
  - `op`, `amount` and `din` changes mid-operation have no effect.
- Step semantics:
  - Left shift: bit 0 <= 0, bit 15 discarded.
  - Logical right: bit 15 <= 0.
  - Arithmetic right: bit 15 preserved.
  - Mode 00 still consumes `amount` cycles and returns `din` unchanged.
- `dout` holds its value from DONE entry until the next DONE entry or reset.
- Reset:
  - State becomes IDLE; `work`, `cnt`, `mode` and `dout` become 0.
  - Outputs after reset: `busy` = 0, `done` = 0, `dout` = 0.
  - Reset during SHIFT aborts with no `done` pulse.
  - Reset has priority over `start` in the same cycle.

## Timing

- Let E be the edge that samples an accepted `start`. `done` is high in the cycle after edge E + N:
  - Default build: N = `amount`.
  - DOUBLE_STEP build: N = ceil(`amount`/2).
  - `amount` = 0: `done` is high in the cycle after E.
- `busy` is high from the cycle after E through the last SHIFT cycle; it is low in the `done` cycle.
- `dout` becomes valid in the same cycle as `done`.
- Back-to-back: `start` held high through the `done` cycle is accepted at that edge, so a new operation begins with no IDLE gap.
- Throughput: one request per N+1 cycles (one request per cycle when `amount` = 0).
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration

- Macro: `SHIFT_SEQ_DOUBLE_STEP_EN`.
- Defined:
  - When `cnt` ≥ 2, a SHIFT cycle applies two steps, `work <= step(step(work))`, and `cnt <= cnt - 2`.
  - When `cnt` = 1, one step is applied.
  - The transition to DONE occurs on the cycle that brings `cnt` to 0.
  - Results are bit-identical to the default build.
- Undefined: one step per SHIFT cycle, as described above.
- The port list is identical in both builds.

## Test plan

- Reset, then idle 3 cycles → `busy` = 0, `done` = 0, `dout` = 0x0000.
- Left shift: `din` = 0x0001, `op` = 01, `amount` = 4 → `done` after 4 cycles (2 with DOUBLE_STEP), `dout` = 0x0010.
- Arithmetic and logical right, `amount` = 3:
  - `din` = 0x8000, `op` = 11 → `dout` = 0xF000.
  - Repeat with `op` = 10 → `dout` = 0x1000.
- Zero amount and pass mode:
  - `amount` = 0, `din` = 0xBEEF → `done` in the cycle after E, `dout` = 0xBEEF, `busy` never high.
  - `op` = 00, `amount` = 15 → `dout` = 0xBEEF after 15 cycles.
- Ignored start and back-to-back:
  - Pulse `start` mid-SHIFT with different `din` → no effect on the result.
  - Hold `start` high in the `done` cycle with `din` = 0x0003, `op` = 01, `amount` = 1 → second `done` one cycle later, `dout` = 0x0006.
- Reset mid-operation: assert `reset` during SHIFT of `amount` = 10 → no `done` pulse, `dout` = 0; the next request completes correctly.
